// File: rtl/pol2rec_rotate.sv
// Polar-to-rectangular conversion by iterative CORDIC rotation.
// One micro-rotation per clock; the result is saturated to 16 bits.
module pol2rec_rotate #(
  parameter int          NITER               = 16,
  parameter logic [25:0] CORDIC_SCALE_FACTOR = 26'd622
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               START,
  input  logic signed [15:0] MODUL,
  input  logic signed [15:0] ANGLE,
  output logic               BUSY,
  output logic               DONE,
  output logic signed [15:0] XOUT,
  output logic signed [15:0] YOUT
);

  localparam int CW = (NITER > 1) ? $clog2(NITER) : 1;
  localparam logic signed [25:0] QUARTER = 26'sd5898240;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ITER,
    ST_DONE
  } state_t;

  // atan(2^-k) in degrees, 16 fractional bits, rounded to nearest
  function automatic logic signed [25:0] atan_f(input int k);
    logic signed [25:0] r;
    case (k)
      0:       r = 26'sd2949120;
      1:       r = 26'sd1740967;
      2:       r = 26'sd919879;
      3:       r = 26'sd466945;
      4:       r = 26'sd234379;
      5:       r = 26'sd117304;
      6:       r = 26'sd58666;
      7:       r = 26'sd29335;
      8:       r = 26'sd14668;
      9:       r = 26'sd7334;
      10:      r = 26'sd3667;
      11:      r = 26'sd1833;
      12:      r = 26'sd917;
      13:      r = 26'sd458;
      14:      r = 26'sd229;
      15:      r = 26'sd115;
      default: r = 26'(32'sd3754937 >>> k);
    endcase
    return r;
  endfunction

  function automatic logic signed [15:0] sat16(
    input logic signed [19:0] v
  );
    logic signed [17:0] s;
    logic signed [15:0] r;
    s = 18'(v >>> 2);
    if (s > 18'sd32767)
      r = 16'sh7fff;
    else if (s < -18'sd32768)
      r = 16'sh8000;
    else
      r = s[15:0];
    return r;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      iter;
  logic signed [15:0] mod_q;
  logic signed [15:0] ang_q;
  logic signed [19:0] x;
  logic signed [19:0] y;
  logic signed [25:0] z;

  logic               last;
  logic [14:0]        mod_pos;
  logic [41:0]        prod;
  logic signed [19:0] m0;
  logic signed [25:0] z_ang;
  logic signed [19:0] x_sh;
  logic signed [19:0] y_sh;
  logic signed [25:0] atan;
  logic               dir;
  logic signed [19:0] x_nx;
  logic signed [19:0] y_nx;
  logic signed [25:0] z_nx;

  always_comb begin
    last    = (iter == CW'(NITER - 1));
    mod_pos = mod_q[15] ? 15'd0 : mod_q[14:0];
    prod    = 42'(mod_pos) * 42'(CORDIC_SCALE_FACTOR);
    // gain-compensated modulus with two guard bits below the LSB
    m0      = 20'((prod >> 10) << 2);
    z_ang   = {ang_q[15], ang_q, 9'd0};
    x_sh    = x >>> iter;
    y_sh    = y >>> iter;
    atan    = atan_f(int'(iter));
    dir     = ~z[25];
    x_nx    = dir ? x - y_sh : x + y_sh;
    y_nx    = dir ? y + x_sh : y - x_sh;
    z_nx    = dir ? z - atan : z + atan;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (START) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY = (state_q == ST_LOAD) || (state_q == ST_ITER);
  assign DONE = (state_q == ST_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iter  <= '0;
      mod_q <= '0;
      ang_q <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      XOUT  <= '0;
      YOUT  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (START) begin
            mod_q <= MODUL;
            ang_q <= ANGLE;
          end
        end
        ST_LOAD: begin
          iter <= '0;
          if (ang_q > 16'sd11520) begin
            x <= '0;
            y <= m0;
            z <= z_ang - QUARTER;
          end else if (ang_q < -16'sd11520) begin
            x <= '0;
            y <= -m0;
            z <= z_ang + QUARTER;
          end else begin
            x <= m0;
            y <= '0;
            z <= z_ang;
          end
        end
        ST_ITER: begin
          x    <= x_nx;
          y    <= y_nx;
          z    <= z_nx;
          iter <= iter + 1'b1;
          if (last) begin
            XOUT <= sat16(x_nx);
            YOUT <= sat16(y_nx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pol2rec_rotate.sv
// Directed bench for pol2rec_rotate: latency, accuracy, saturation,
// START filtering, output hold and asynchronous reset behaviour.
module tb_pol2rec_rotate;

  logic               clock;
  logic               reset;
  logic               START;
  logic signed [15:0] MODUL;
  logic signed [15:0] ANGLE;
  logic               BUSY;
  logic               DONE;
  logic signed [15:0] XOUT;
  logic signed [15:0] YOUT;

  int errors = 0;
  int checks = 0;

  pol2rec_rotate dut (
    .clock(clock),
    .reset(reset),
    .START(START),
    .MODUL(MODUL),
    .ANGLE(ANGLE),
    .BUSY (BUSY),
    .DONE (DONE),
    .XOUT (XOUT),
    .YOUT (YOUT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one conversion; report the edge of the first DONE
  task automatic run_conv(
    input  logic signed [15:0] m,
    input  logic signed [15:0] a,
    output int                 dedge,
    output logic signed [15:0] xo,
    output logic signed [15:0] yo,
    output int                 busy_bad
  );
    START = 1'b1;
    MODUL = m;
    ANGLE = a;
    tick();
    START = 1'b0;
    MODUL = 16'sd7;
    ANGLE = -16'sd3000;
    dedge = -1;
    busy_bad = 0;
    xo = '0;
    yo = '0;
    for (int k = 1; k <= 40 && dedge < 0; k++) begin
      tick();
      if (DONE) begin
        dedge = k;
        xo = XOUT;
        yo = YOUT;
      end else if (k <= 16 && BUSY !== 1'b1) begin
        busy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    START = 1'b0;
    MODUL = 16'sd1000;
    ANGLE = 16'sd0;
    tick();
    START = 1'b1;
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b want=0", BUSY);
    end
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b want=0", DONE);
    end
    checks++;
    if (XOUT !== 16'sd0) begin
      errors++;
      $display("FAIL reset_xout got=%0d want=0", XOUT);
    end
    checks++;
    if (YOUT !== 16'sd0) begin
      errors++;
      $display("FAIL reset_yout got=%0d want=0", YOUT);
    end
    START = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int d;
    int bb;
    logic signed [15:0] xo;
    logic signed [15:0] yo;
    run_conv(16'sd1000, 16'sd0, d, xo, yo, bb);
    checks++;
    if (d !== 17) begin
      errors++;
      $display("FAIL zero_latency got=%0d want=17", d);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL zero_busy low_cycles=%0d want=0", bb);
    end
    checks++;
    if (xo < 997 || xo > 1003) begin
      errors++;
      $display("FAIL zero_x got=%0d want=997..1003", xo);
    end
    checks++;
    if (yo < -3 || yo > 3) begin
      errors++;
      $display("FAIL zero_y got=%0d want=-3..3", yo);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL zero_after done=%b busy=%b want=0,0", DONE, BUSY);
    end
  endtask

  task automatic test_angles();
    int d;
    int bb;
    logic signed [15:0] xo;
    logic signed [15:0] yo;
    logic signed [15:0] mv [5] = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
    logic signed [15:0] av [5] = '{16'sd11520, 16'sd23040, -16'sd5760, -16'sd23040, 16'sd3840};
    int xl [5] = '{-3, -1003, 704, -1003, 863};
    int xh [5] = '{3, -997, 710, -997, 869};
    int yl [5] = '{997, -3, -710, -3, 497};
    int yh [5] = '{1003, 3, -704, 3, 503};
    for (int n = 0; n < 5; n++) begin
      run_conv(mv[n], av[n], d, xo, yo, bb);
      tick();
      checks++;
      if (d !== 17) begin
        errors++;
        $display("FAIL angle%0d_latency got=%0d want=17", n, d);
      end
      checks++;
      if (xo < xl[n] || xo > xh[n]) begin
        errors++;
        $display("FAIL angle%0d_x got=%0d want=%0d..%0d", n, xo, xl[n], xh[n]);
      end
      checks++;
      if (yo < yl[n] || yo > yh[n]) begin
        errors++;
        $display("FAIL angle%0d_y got=%0d want=%0d..%0d", n, yo, yl[n], yh[n]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dcount = 0;
    int first = -1;
    logic signed [15:0] xo = '0;
    START = 1'b1;
    MODUL = 16'sd500;
    ANGLE = 16'sd0;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        START = 1'b1;
        MODUL = 16'sd2000;
      end else begin
        START = 1'b0;
      end
      tick();
      if (DONE) begin
        dcount++;
        if (first < 0) begin
          first = k;
          xo = XOUT;
        end
      end
    end
    START = 1'b0;
    checks++;
    if (dcount !== 1 || first !== 17) begin
      errors++;
      $display("FAIL ignore_done count=%0d edge=%0d want=1,17", dcount, first);
    end
    checks++;
    if (xo < 497 || xo > 503) begin
      errors++;
      $display("FAIL ignore_x got=%0d want=497..503", xo);
    end
  endtask

  task automatic test_limits();
    int d;
    int bb;
    logic signed [15:0] xo;
    logic signed [15:0] yo;
    run_conv(-16'sd100, 16'sd3000, d, xo, yo, bb);
    tick();
    checks++;
    if (xo < -1 || xo > 1 || yo < -1 || yo > 1) begin
      errors++;
      $display("FAIL neg_modul got=%0d,%0d want=0,0", xo, yo);
    end
    run_conv(16'sd32767, 16'sd0, d, xo, yo, bb);
    checks++;
    if (xo < 32764 || xo > 32767) begin
      errors++;
      $display("FAIL saturate_x got=%0d want=32764..32767", xo);
    end
    // outputs must hold while idle inputs wander
    for (int k = 0; k < 6; k++) begin
      MODUL = 16'(k * 111);
      ANGLE = 16'(k * 977);
      tick();
    end
    checks++;
    if (XOUT !== xo || YOUT !== yo) begin
      errors++;
      $display("FAIL hold got=%0d,%0d want=%0d,%0d", XOUT, YOUT, xo, yo);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int bb;
    int first = -1;
    logic signed [15:0] xo;
    logic signed [15:0] yo;
    run_conv(16'sd1000, 16'sd0, d, xo, yo, bb);
    START = 1'b1;
    MODUL = 16'sd2000;
    ANGLE = 16'sd0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignored busy=%b done=%b want=0,0", BUSY, DONE);
    end
    MODUL = 16'sd300;
    tick();
    START = 1'b0;
    MODUL = 16'sd5000;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b want=1", BUSY);
    end
    xo = '0;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      tick();
      if (DONE) begin
        first = k;
        xo = XOUT;
      end
    end
    checks++;
    if (first !== 17) begin
      errors++;
      $display("FAIL b2b_latency got=%0d want=17", first);
    end
    checks++;
    if (xo < 297 || xo > 303) begin
      errors++;
      $display("FAIL b2b_x got=%0d want=297..303", xo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int d;
    int bb;
    int dcount = 0;
    logic signed [15:0] xo;
    logic signed [15:0] yo;
    START = 1'b1;
    MODUL = 16'sd1000;
    ANGLE = 16'sd0;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags busy=%b done=%b want=0,0", BUSY, DONE);
    end
    checks++;
    if (XOUT !== 16'sd0 || YOUT !== 16'sd0) begin
      errors++;
      $display("FAIL mid_reset_out got=%0d,%0d want=0,0", XOUT, YOUT);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (DONE) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      errors++;
      $display("FAIL mid_reset_nodone count=%0d want=0", dcount);
    end
    run_conv(16'sd1000, 16'sd0, d, xo, yo, bb);
    checks++;
    if (d !== 17 || xo < 997 || xo > 1003) begin
      errors++;
      $display("FAIL mid_reset_rerun edge=%0d x=%0d want=17,997..1003", d, xo);
    end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    START = 1'b0;
    MODUL = '0;
    ANGLE = '0;
    test_reset();
    test_zero();
    test_angles();
    test_ignore_start();
    test_limits();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pol2rec_rotate.md
POL2REC_ROTATE -- requirements
Module: pol2rec_rotate

Interface
REQ-001 Parameter NITER, default 16, number of CORDIC rotation iterations (one per clock).
REQ-002 Parameter CORDIC_SCALE_FACTOR, default 26'd622, CORDIC gain compensation 0.607252935 in 0Q10.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 START  input  1  request a conversion; sampled on the rising clock edge.
REQ-007 MODUL  input  16  vector modulus, signed two's complement integer.
REQ-008 ANGLE  input  16  vector angle in degrees, signed 9Q7, valid range -23040..+23040 (-180.0..+180.0 degrees).
REQ-009 BUSY  output  1  conversion in progress.
REQ-010 DONE  output  1  one-cycle pulse: XOUT/YOUT were just updated.
REQ-011 XOUT  output  16  signed result MODUL*cos(ANGLE).
REQ-012 YOUT  output  16  signed result MODUL*sin(ANGLE).

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, ITER, DONE.
REQ-014 IDLE with START=1 at an edge: capture MODUL and ANGLE into internal registers; next state LOAD. Otherwise stay in IDLE.
REQ-015 START SHALL be ignored in LOAD, ITER and DONE; no queuing.
REQ-016 LOAD, 1 cycle: clamp negative MODUL to 0; prescale M = (MODUL * CORDIC_SCALE_FACTOR) >>> 10, arithmetic shift; apply the quadrant pre-rotation; clear the iteration counter i; next state ITER.
REQ-017 Quadrant pre-rotation cases:
  - ANGLE > +11520: X0=0, Y0=+M, Z0=ANGLE-11520.
  - ANGLE < -11520: X0=0, Y0=-M, Z0=ANGLE+11520.
  - otherwise: X0=M, Y0=0, Z0=ANGLE.
REQ-018 X/Y datapath: internal X, Y registers are 20-bit signed. The value is M left-shifted by 2 guard bits, giving 2 bits of headroom.
REQ-019 Z datapath: internal Z register is 26-bit signed, 9 integer + 16 fractional degree bits. ANGLE is extended by a left shift of 9.
REQ-020 ITER, per cycle, with d = sign(Z), where Z>=0 gives d=+1:
  - X <= X - d*(Y>>>i)
  - Y <= Y + d*(X>>>i)
  - Z <= Z - d*ATAN[i]
  - i <= i+1
REQ-021 ATAN[i] SHALL be a constant table of atan(2^-i) in degrees, in the Z format, rounded to nearest, for i = 0..NITER-1.
REQ-022 After the iteration with i = NITER-1, the FSM SHALL load XOUT = sat16(X >>> 2) and YOUT = sat16(Y >>> 2), then go to DONE.
REQ-023 sat16 SHALL clamp to [-32768, +32767].
REQ-024 DONE SHALL be held for exactly 1 cycle, then the FSM returns to IDLE.
REQ-025 BUSY = 1 in LOAD and ITER; 0 in IDLE and DONE. DONE = 1 only in state DONE.
REQ-026 Latency: with the START capture edge as edge 0, DONE is high from edge NITER+1 to edge NITER+2 (edges 17 to 18 for NITER=16).
REQ-027 Back-to-back: a START asserted on the edge that leaves DONE is ignored. A START asserted in the following IDLE cycle is accepted.
REQ-028 XOUT/YOUT SHALL hold their value between DONE pulses and SHALL change only on the edge entering DONE.
REQ-029 Changes on MODUL or ANGLE after the capture edge SHALL NOT affect the conversion in progress.
REQ-030 ANGLE outside +/-23040 is outside the contract; the FSM SHALL still complete in the normal latency, with the result undefined.
REQ-031 Accuracy: for |ANGLE| <= 23040 and 0 <= MODUL <= 16383, |XOUT - MODUL*cos| <= 3 LSB and |YOUT - MODUL*sin| <= 3 LSB.

Reset
REQ-032 While reset = 0, regardless of clock: state=IDLE, i=0, BUSY=0, DONE=0, XOUT=0, YOUT=0, and internal X/Y/Z = 0.
REQ-033 A reset assertion mid-conversion SHALL abort it without a DONE pulse. The first START after reset release SHALL be handled normally.

Verification
REQ-034 MODUL=1000, ANGLE=0 -> DONE at edge 17; XOUT in 997..1003, YOUT in -3..3; BUSY high for edges 1-16.
REQ-035 MODUL=1000, ANGLE=11520 (90 deg) -> XOUT in -3..3, YOUT in 997..1003.
REQ-036 MODUL=1000, ANGLE=23040 (180 deg) -> XOUT in -1003..-997, YOUT in -3..3. MODUL=1000, ANGLE=-5760 (-45 deg) -> XOUT in 704..710, YOUT in -710..-704.
REQ-037 START with MODUL=500, ANGLE=0, then START again at edge 5 with MODUL=2000 -> a single DONE at edge 17 with XOUT ~500; the second request is ignored.
REQ-038 MODUL=-100, any ANGLE -> XOUT=0, YOUT=0 (within 1 LSB). MODUL=32767, ANGLE=0 -> XOUT in 32764..32767, with no wrap to negative.
REQ-039 Reset asserted at edge 8 of a conversion -> all outputs 0 immediately and no DONE. A START after release with MODUL=1000, ANGLE=0 -> normal result at capture edge +17.
